// File: rtl/vproc_dispatcher.sv
// vproc_dispatcher: in-order issue controller between the vector decoder and
// the execution units. It holds one decoded instruction and routes it to one
// unit by its op_unit code. A vreg pending-write scoreboard blocks RAW/WAW
// hazards, per-unit credit counters limit outstanding work, and configuration
// instructions wait until every unit has drained.
module vproc_dispatcher #(
    parameter int UNIT_CNT  = 5,   // real execution units, index == op_unit code
    parameter int OUTST_MAX = 4,   // outstanding instructions per unit (1..15)
    parameter int ID_W      = 3    // instruction id width
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [2:0]          instr_unit_i,
    input  logic [ID_W-1:0]     instr_id_i,
    input  logic [31:0]         instr_rd_vregs_i,
    input  logic [31:0]         instr_wr_vregs_i,
    output logic [UNIT_CNT-1:0] unit_valid_o,
    input  logic [UNIT_CNT-1:0] unit_ready_i,
    output logic [ID_W-1:0]     unit_id_o,
    output logic                cfg_valid_o,
    input  logic                cfg_ready_i,
    input  logic [UNIT_CNT-1:0] done_unit_i,
    input  logic [31:0]         done_clr_vregs_i,
    output logic [31:0]         pend_vregs_o,
    output logic                idle_o,
    output logic                err_o
);

    // Counters hold 0..15, enough for the largest legal OUTST_MAX.
    localparam int               CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(OUTST_MAX);
    localparam logic [2:0]       UNIT_CFG  = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN,    // normal issue to execution units
        ST_DRAIN,  // CFG held, waiting for all units and the scoreboard to empty
        ST_CFG     // CFG presented to the config unit
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;

    logic              hold_valid_q;
    logic [2:0]        hold_unit_q;
    logic [ID_W-1:0]   hold_id_q;
    logic [31:0]       hold_rd_q;
    logic [31:0]       hold_wr_q;

    logic [31:0]       pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q [UNIT_CNT];
    logic [CNT_W-1:0]  cnt_d [UNIT_CNT];
    logic              err_q, err_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                hazard_free;
    logic [UNIT_CNT-1:0] cnt_room;
    logic [UNIT_CNT-1:0] cnt_zero;
    logic [UNIT_CNT-1:0] issue_fire;
    logic [UNIT_CNT-1:0] underflow;
    logic                all_drained;
    logic                cfg_fire;
    logic                hold_fire;
    logic                accept;
    logic                accept_legal;
    logic                accept_illegal;

    // Per-unit credit status, derived only from registered counters.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        cnt_room = '0;
        cnt_zero = '0;
        for (int u = 0; u < UNIT_CNT; u++) begin
            cnt_room[u] = (cnt_q[u] < CNT_LIMIT);
            cnt_zero[u] = (cnt_q[u] == '0);
        end
    end

    // The held instruction may issue only if none of its vregs has a pending
    // write; the check uses registered pend_q only (no bypass of clears).
    assign hazard_free = (((hold_rd_q | hold_wr_q) & pend_q) == '0);

    // Drain condition for CFG: no unit has work outstanding, no write pending.
    assign all_drained = (&cnt_zero) && (pend_q == '0);

    // Issue valid: one-hot by the held unit code; a CFG code matches no unit.
    always_comb begin
        unit_valid_o = '0;
        for (int u = 0; u < UNIT_CNT; u++) begin
            unit_valid_o[u] = hold_valid_q && (state_q == ST_RUN) &&
                              (hold_unit_q == 3'(u)) && hazard_free && cnt_room[u];
        end
    end

    assign issue_fire  = unit_valid_o & unit_ready_i;
    assign cfg_valid_o = (state_q == ST_CFG);
    assign cfg_fire    = cfg_valid_o && cfg_ready_i;
    assign hold_fire   = (|issue_fire) || cfg_fire;

    // The holding register accepts when empty or when it drains this cycle.
    assign instr_ready_o  = !hold_valid_q || hold_fire;
    assign accept         = instr_valid_i && instr_ready_o;
    assign accept_legal   = accept && (instr_unit_i <= UNIT_CFG);
    assign accept_illegal = accept && (instr_unit_i > UNIT_CFG);

    assign unit_id_o    = hold_id_q;
    assign pend_vregs_o = pend_q;
    assign idle_o       = !hold_valid_q && all_drained;
    assign err_o        = err_q;

    // Credit counter update: issue and done on one unit cancel; a done at
    // zero saturates and is flagged as an underflow.
    always_comb begin
        underflow = '0;
        for (int u = 0; u < UNIT_CNT; u++) begin
            cnt_d[u] = cnt_q[u];
            case ({issue_fire[u], done_unit_i[u]})
                2'b10: cnt_d[u] = cnt_q[u] + CNT_W'(1);
                2'b01: begin
                    if (cnt_zero[u]) begin
                        underflow[u] = 1'b1;
                    end else begin
                        cnt_d[u] = cnt_q[u] - CNT_W'(1);
                    end
                end
                default: cnt_d[u] = cnt_q[u];
            endcase
        end
    end

    // Scoreboard: clears apply first, so a same-cycle set of that bit wins.
    // CFG never sets bits because it never fires on issue_fire.
    always_comb begin
        pend_d = pend_q & ~done_clr_vregs_i;
        if (|issue_fire) begin
            pend_d = pend_d | hold_wr_q;
        end
    end

    // Error pulse source: illegal unit code accepted, or counter underflow.
    assign err_d = accept_illegal || (|underflow);

    // Next-state logic for the CFG serialisation FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (hold_valid_q && (hold_unit_q == UNIT_CFG)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (all_drained) begin
                    state_d = ST_CFG;
                end
            end
            ST_CFG: begin
                if (cfg_ready_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (async_rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding register: load a legal instruction, empty on handshake.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            hold_valid_q <= 1'b0;
            hold_unit_q  <= '0;
            hold_id_q    <= '0;
            hold_rd_q    <= '0;
            hold_wr_q    <= '0;
        end else if (accept_legal) begin
            hold_valid_q <= 1'b1;
            hold_unit_q  <= instr_unit_i;
            hold_id_q    <= instr_id_i;
            hold_rd_q    <= instr_rd_vregs_i;
            hold_wr_q    <= instr_wr_vregs_i;
        end else if (hold_fire) begin
            hold_valid_q <= 1'b0;
        end
    end

    // Scoreboard, credit counters and error pulse.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            pend_q <= '0;
            err_q  <= 1'b0;
            // NOTE: the counter array is control state, not data storage, so
            // every entry is reset; leaving it unreset would corrupt credits.
            for (int u = 0; u < UNIT_CNT; u++) begin
                cnt_q[u] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
            for (int u = 0; u < UNIT_CNT; u++) begin
                cnt_q[u] <= cnt_d[u];
            end
        end
    end

endmodule

// File: tb/tb_vproc_dispatcher.sv
// Directed testbench for vproc_dispatcher: issue latency, RAW blocking,
// credit limits, CFG drain, illegal codes/underflow and mid-issue reset.
module tb_vproc_dispatcher;

    logic        clk_i;
    logic        async_rst_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [2:0]  instr_unit_i;
    logic [2:0]  instr_id_i;
    logic [31:0] instr_rd_vregs_i;
    logic [31:0] instr_wr_vregs_i;
    logic [4:0]  unit_valid_o;
    logic [4:0]  unit_ready_i;
    logic [2:0]  unit_id_o;
    logic        cfg_valid_o;
    logic        cfg_ready_i;
    logic [4:0]  done_unit_i;
    logic [31:0] done_clr_vregs_i;
    logic [31:0] pend_vregs_o;
    logic        idle_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    vproc_dispatcher #(
        .UNIT_CNT (5),
        .OUTST_MAX(4),
        .ID_W     (3)
    ) dut (
        .clk_i           (clk_i),
        .async_rst_i     (async_rst_i),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .instr_unit_i    (instr_unit_i),
        .instr_id_i      (instr_id_i),
        .instr_rd_vregs_i(instr_rd_vregs_i),
        .instr_wr_vregs_i(instr_wr_vregs_i),
        .unit_valid_o    (unit_valid_o),
        .unit_ready_i    (unit_ready_i),
        .unit_id_o       (unit_id_o),
        .cfg_valid_o     (cfg_valid_o),
        .cfg_ready_i     (cfg_ready_i),
        .done_unit_i     (done_unit_i),
        .done_clr_vregs_i(done_clr_vregs_i),
        .pend_vregs_o    (pend_vregs_o),
        .idle_o          (idle_o),
        .err_o           (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Count one comparison and report it if the observed value differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one instruction for a single edge; it must be accepted.
    task automatic send(input logic [2:0] unit, input logic [2:0] id,
                        input logic [31:0] rd, input logic [31:0] wr, input string tag);
        instr_valid_i    = 1'b1;
        instr_unit_i     = unit;
        instr_id_i       = id;
        instr_rd_vregs_i = rd;
        instr_wr_vregs_i = wr;
        #1;
        check({tag, "_ready"}, 32'(instr_ready_o), 32'h1);
        tick();
        instr_valid_i    = 1'b0;
        instr_unit_i     = 3'd0;
        instr_id_i       = 3'd0;
        instr_rd_vregs_i = 32'h0;
        instr_wr_vregs_i = 32'h0;
    endtask

    initial begin
        async_rst_i      = 1'b1;
        instr_valid_i    = 1'b0;
        instr_unit_i     = 3'd0;
        instr_id_i       = 3'd0;
        instr_rd_vregs_i = 32'h0;
        instr_wr_vregs_i = 32'h0;
        unit_ready_i     = 5'h00;
        cfg_ready_i      = 1'b0;
        done_unit_i      = 5'h00;
        done_clr_vregs_i = 32'h0;

        #22;
        async_rst_i = 1'b0;
        #1;
        // ---------------- reset state ----------------
        check("rst_unit_valid", 32'(unit_valid_o), 32'h0);
        check("rst_cfg_valid",  32'(cfg_valid_o),  32'h0);
        check("rst_ready",      32'(instr_ready_o), 32'h1);
        check("rst_unit_id",    32'(unit_id_o),    32'h0);
        check("rst_pend",       pend_vregs_o,      32'h0);
        check("rst_idle",       32'(idle_o),       32'h1);
        check("rst_err",        32'(err_o),        32'h0);
        tick();

        // ---------------- ALU op, latency 1 ----------------
        unit_ready_i = 5'b00010;
        send(3'd1, 3'd3, 32'h0, 32'h4, "alu");
        check("alu_valid",  32'(unit_valid_o), 32'h02);
        check("alu_id",     32'(unit_id_o),    32'h3);
        check("alu_pend0",  pend_vregs_o,      32'h0);
        tick();
        check("alu_pend",   pend_vregs_o,      32'h4);
        check("alu_valid_after", 32'(unit_valid_o), 32'h0);
        check("alu_busy",   32'(idle_o),       32'h0);
        done_unit_i = 5'b00010; done_clr_vregs_i = 32'h4;
        tick();
        done_unit_i = 5'h00; done_clr_vregs_i = 32'h0;
        check("alu_clr_pend", pend_vregs_o, 32'h0);
        check("alu_idle",     32'(idle_o),  32'h1);

        // ---------------- RAW hazard ----------------
        unit_ready_i = 5'h1F;
        send(3'd2, 3'd1, 32'h0, 32'h10, "mul");
        check("mul_valid", 32'(unit_valid_o), 32'h04);
        send(3'd1, 3'd2, 32'h10, 32'h0, "raw_alu");
        check("raw_blocked0", 32'(unit_valid_o), 32'h0);
        check("raw_pend",     pend_vregs_o,      32'h10);
        tick();
        check("raw_blocked1", 32'(unit_valid_o), 32'h0);
        done_unit_i = 5'b00100; done_clr_vregs_i = 32'h10;
        tick();
        done_unit_i = 5'h00; done_clr_vregs_i = 32'h0;
        check("raw_release", 32'(unit_valid_o), 32'h02);
        check("raw_id",      32'(unit_id_o),    32'h2);
        tick();
        done_unit_i = 5'b00010;
        tick();
        done_unit_i = 5'h00;
        check("raw_idle", 32'(idle_o), 32'h1);

        // ---------------- credit limit on LSU ----------------
        for (int i = 0; i < 4; i++) begin
            send(3'd0, 3'(i), 32'h0, 32'h0, "lsu");
        end
        check("lsu4_valid", 32'(unit_valid_o), 32'h01);
        send(3'd0, 3'd4, 32'h0, 32'h0, "lsu5");
        check("lsu5_blocked", 32'(unit_valid_o), 32'h0);
        check("lsu5_not_ready", 32'(instr_ready_o), 32'h0);
        tick();
        check("lsu5_still_blocked", 32'(unit_valid_o), 32'h0);
        done_unit_i = 5'b00001;
        tick();
        check("lsu5_valid", 32'(unit_valid_o), 32'h01);
        // Issue of LSU5 and a done in the same cycle: count stays 3.
        send(3'd0, 3'd5, 32'h0, 32'h0, "lsu6");
        done_unit_i = 5'h00;
        check("lsu6_valid", 32'(unit_valid_o), 32'h01);
        send(3'd0, 3'd6, 32'h0, 32'h0, "lsu7");
        check("lsu7_blocked", 32'(unit_valid_o), 32'h0);
        done_unit_i = 5'b00001;
        repeat (5) tick();
        done_unit_i = 5'h00;
        check("lsu_idle", 32'(idle_o), 32'h1);
        check("lsu_err",  32'(err_o),  32'h0);

        // ---------------- CFG drain ----------------
        send(3'd1, 3'd4, 32'h0, 32'h1, "cfg_alu");
        send(3'd3, 3'd5, 32'h0, 32'h2, "cfg_sld");
        check("cfg_sld_valid", 32'(unit_valid_o), 32'h08);
        send(3'd5, 3'd6, 32'h0, 32'h80, "cfg");
        check("cfg_wait0",  32'(cfg_valid_o),   32'h0);
        check("cfg_hold",   32'(instr_ready_o), 32'h0);
        check("cfg_pend",   pend_vregs_o,       32'h3);
        tick();
        check("cfg_wait1",  32'(cfg_valid_o),   32'h0);
        check("cfg_no_unit", 32'(unit_valid_o), 32'h0);
        done_unit_i = 5'b00010; done_clr_vregs_i = 32'h1;
        tick();
        done_unit_i = 5'h00; done_clr_vregs_i = 32'h0;
        check("cfg_wait2",  32'(cfg_valid_o),   32'h0);
        check("cfg_pend2",  pend_vregs_o,       32'h2);
        done_unit_i = 5'b01000; done_clr_vregs_i = 32'h2;
        tick();
        done_unit_i = 5'h00; done_clr_vregs_i = 32'h0;
        tick();
        check("cfg_valid",  32'(cfg_valid_o),   32'h1);
        check("cfg_ready_low", 32'(instr_ready_o), 32'h0);
        tick();
        check("cfg_valid_hold", 32'(cfg_valid_o), 32'h1);
        cfg_ready_i = 1'b1;
        #1;
        check("cfg_ready_hs", 32'(instr_ready_o), 32'h1);
        tick();
        cfg_ready_i = 1'b0;
        check("cfg_done",      32'(cfg_valid_o), 32'h0);
        check("cfg_idle",      32'(idle_o),      32'h1);
        check("cfg_no_pend",   pend_vregs_o,     32'h0);

        // ---------------- illegal code and underflow ----------------
        send(3'd7, 3'd1, 32'h0, 32'hFF, "ill");
        check("ill_err",      32'(err_o),        32'h1);
        check("ill_no_issue", 32'(unit_valid_o), 32'h0);
        check("ill_no_pend",  pend_vregs_o,      32'h0);
        tick();
        check("ill_err_off",  32'(err_o),        32'h0);
        done_unit_i = 5'b00100;
        tick();
        done_unit_i = 5'h00;
        check("uflow_err",     32'(err_o),  32'h1);
        tick();
        check("uflow_err_off", 32'(err_o),  32'h0);
        check("uflow_idle",    32'(idle_o), 32'h1);

        // ---------------- reset mid-issue ----------------
        unit_ready_i = 5'b00010;
        send(3'd1, 3'd1, 32'h0, 32'hFF, "mr_alu");
        send(3'd3, 3'd2, 32'h0, 32'h0, "mr_sld");
        check("mr_sld_valid", 32'(unit_valid_o), 32'h08);
        check("mr_pend",      pend_vregs_o,      32'hFF);
        #2;
        async_rst_i = 1'b1;
        #1;
        check("mr_unit_valid", 32'(unit_valid_o),  32'h0);
        check("mr_pend_clr",   pend_vregs_o,       32'h0);
        check("mr_ready",      32'(instr_ready_o), 32'h1);
        check("mr_id",         32'(unit_id_o),     32'h0);
        check("mr_cfg",        32'(cfg_valid_o),   32'h0);
        repeat (2) @(posedge clk_i);
        #3;
        async_rst_i = 1'b0;
        tick();
        check("mr_idle",       32'(idle_o),        32'h1);
        check("mr_valid_after", 32'(unit_valid_o), 32'h0);
        check("mr_err",        32'(err_o),         32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
